// File: rtl/rv32i_types.sv
// Shared types for the instruction-memory responder: word type, FSM states, NOP.
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } imem_state_t;

  localparam rv32i_word NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/imem_array.sv
// DEPTH_WORDS x 32 storage with one synchronous write and one synchronous read port.
// A read and write to the same word on one edge returns the old contents.
module imem_array
  import rv32i_types::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic                           i_we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_waddr,
  input  rv32i_word                      i_wdata,
  input  logic                           i_re,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_raddr,
  output rv32i_word                      o_rdata
);

  rv32i_word r_mem [DEPTH_WORDS];
  rv32i_word r_rdata;

  // No reset: contents survive rst, and the read register is masked by the top.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/inst_mem_responder.sv
// Fixed-latency instruction fetch responder with a preload write port.
// Define IMEM_ADDR_CHECK_EN to fault misaligned/out-of-range fetches (NOP + read_error).
module inst_mem_responder
  import rv32i_types::*;
#(
  parameter int        LATENCY     = 2,
  parameter int        DEPTH_WORDS = 256,
  parameter rv32i_word BASE_ADDR   = 32'h0000_0060
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      instr_read,
  input  rv32i_word instr_mem_address,
  output logic      instr_mem_resp,
  output rv32i_word in,
  input  logic      prog_we,
  input  rv32i_word prog_addr,
  input  rv32i_word prog_data,
  output logic      read_error
);

  localparam int         IDX_W  = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  imem_state_t      r_state, w_next;
  logic [3:0]       r_cnt, w_cnt_nxt;
  rv32i_word        r_addr, w_addr_nxt;
  logic             r_nop_sel;
  logic             w_enter;
  rv32i_word        w_rd_addr;
  logic [IDX_W-1:0] w_rd_idx, w_wr_idx;
  logic             w_rd_fault, w_we, w_re;
  rv32i_word        w_arr_rdata;

  // Word index relative to BASE_ADDR; upper bits drop so the window wraps.
  function automatic logic [IDX_W-1:0] f_idx(input rv32i_word a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

`ifdef IMEM_ADDR_CHECK_EN
  localparam rv32i_word LAST_ADDR = BASE_ADDR + rv32i_word'(4 * DEPTH_WORDS) - 32'd4;

  function automatic logic f_fault(input rv32i_word a);
    return (a[1:0] != 2'b00) || (a < BASE_ADDR) || (a > LAST_ADDR);
  endfunction

  assign w_rd_fault = f_fault(w_rd_addr);
  assign w_we       = prog_we && !f_fault(prog_addr);
  assign read_error = instr_mem_resp && r_nop_sel;
`else
  assign w_rd_fault = 1'b0;
  assign w_we       = prog_we;
  assign read_error = 1'b0;
`endif

  // The array read fires on the edge entering RESP, so the LATENCY=1 path
  // must read straight from the request bus rather than the capture register.
  assign w_rd_addr = (r_state == IDLE) ? instr_mem_address : r_addr;
  assign w_rd_idx  = f_idx(w_rd_addr);
  assign w_wr_idx  = f_idx(prog_addr);
  assign w_re      = w_enter && !w_rd_fault;

  always_comb begin
    w_next     = r_state;
    w_cnt_nxt  = r_cnt;
    w_addr_nxt = r_addr;
    w_enter    = 1'b0;
    case (r_state)
      IDLE: begin
        if (instr_read) begin
          w_addr_nxt = instr_mem_address;
          w_cnt_nxt  = LAT_M1;
          if (LATENCY == 1) begin
            w_next  = RESP;
            w_enter = 1'b1;
          end else begin
            w_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (!instr_read) begin
          w_next    = IDLE;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            w_next  = RESP;
            w_enter = 1'b1;
          end
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_nop_sel <= 1'b1;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      r_addr  <= w_addr_nxt;
      if (w_enter) r_nop_sel <= w_rd_fault;
    end
  end

  // r_nop_sel also covers reset: the array read register is not cleared.
  assign instr_mem_resp = (r_state == RESP);
  assign in             = r_nop_sel ? NOP_INSTR : w_arr_rdata;

  imem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk    (clk),
    .i_we   (w_we),
    .i_waddr(w_wr_idx),
    .i_wdata(prog_data),
    .i_re   (w_re),
    .i_raddr(w_rd_idx),
    .o_rdata(w_arr_rdata)
  );

endmodule

// File: tb/tb_inst_mem_responder.sv
// Bench: four responders (LATENCY 1..4) sharing one preload bus, checked against a word-array model.
module tb_inst_mem_responder;
  import rv32i_types::*;

  localparam logic [31:0] BASE  = 32'h0000_0060;
  localparam int          DEPTH = 256;
  localparam logic [31:0] LAST  = BASE + 32'(4 * DEPTH) - 32'd4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  rd  = '0;
  logic [31:0] addr [4];
  logic [3:0]  resp, err;
  logic [31:0] dout [4];
  logic        pwe   = 1'b0;
  logic [31:0] paddr = '0;
  logic [31:0] pdata = '0;

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_dut
      inst_mem_responder #(
        .LATENCY(g + 1), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)
      ) u_dut (
        .clk(clk), .rst(rst), .instr_read(rd[g]), .instr_mem_address(addr[g]),
        .instr_mem_resp(resp[g]), .in(dout[g]), .prog_we(pwe), .prog_addr(paddr),
        .prog_data(pdata), .read_error(err[g])
      );
    end
  endgenerate

  logic [31:0] mdl [DEPTH];
  logic [31:0] last_in [4];
  int          last_resp [4];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit m_fault(input logic [31:0] a);
`ifdef IMEM_ADDR_CHECK_EN
    return (a % 4 != 0) || (a < BASE) || (a > LAST);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'((off / 4) % DEPTH);
  endfunction

  function automatic logic [31:0] m_word(input logic [31:0] a);
    return m_fault(a) ? NOP_INSTR : mdl[m_idx(a)];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input logic [31:0] a, input logic [31:0] d);
    pwe = 1'b1; paddr = a; pdata = d;
    tick;
    pwe = 1'b0;
    if (!m_fault(a)) mdl[m_idx(a)] = d;
  endtask

  // One fetch on lane ln (LATENCY ln+1). Response is visible just after edge accept+LATENCY-1.
  task automatic fetch(input int ln, input logic [31:0] a, input bit hold, input string nm);
    int acc, exp_c;
    logic [31:0] ew;
    bit ee, got;
    ew = m_word(a);
    ee = m_fault(a);
    rd[ln] = 1'b1;
    addr[ln] = a;
    acc = cyc + 1;
    if (last_resp[ln] + 2 > acc) acc = last_resp[ln] + 2;
    exp_c = acc + ln;
    got = 1'b0;
    while (!got && cyc < exp_c + 4) begin
      tick;
      if (resp[ln]) got = 1'b1;
      else if (cyc >= acc) addr[ln] = $urandom;
    end
    n_chk++;
    if (!got || cyc != exp_c)
      $display("FAIL %s resp_cycle lane%0d: got cycle %0d (seen=%0b) expected %0d", nm, ln, cyc, got, exp_c);
    else n_pass++;
    n_chk++;
    if (dout[ln] !== ew) $display("FAIL %s data lane%0d addr %h: got %h expected %h", nm, ln, a, dout[ln], ew);
    else n_pass++;
    n_chk++;
    if (err[ln] !== ee) $display("FAIL %s read_error lane%0d: got %b expected %b", nm, ln, err[ln], ee);
    else n_pass++;
    last_in[ln] = ew;
    last_resp[ln] = cyc;
    if (!hold) rd[ln] = 1'b0;
    tick;
    n_chk++;
    if (resp[ln] !== 1'b0 || err[ln] !== 1'b0)
      $display("FAIL %s pulse_width lane%0d: resp=%b err=%b expected 0/0", nm, ln, resp[ln], err[ln]);
    else n_pass++;
    n_chk++;
    if (dout[ln] !== last_in[ln]) $display("FAIL %s hold lane%0d: got %h expected %h", nm, ln, dout[ln], last_in[ln]);
    else n_pass++;
  endtask

  task automatic test_reset;
    tick; tick;
    for (int l = 0; l < 4; l++) begin
      n_chk++;
      if (resp[l] !== 1'b0 || err[l] !== 1'b0 || dout[l] !== NOP_INSTR)
        $display("FAIL reset lane%0d: resp=%b err=%b in=%h expected 0/0/%h", l, resp[l], err[l], dout[l], NOP_INSTR);
      else n_pass++;
    end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_preload;
    for (int i = 0; i < DEPTH; i++) prog(BASE + 32'(4 * i), $urandom);
    prog(32'h60, 32'h00A0_0093);
  endtask

  task automatic test_basic;
    fetch(1, 32'h60, 1'b0, "basic_l2");
    fetch(3, 32'h64, 1'b0, "basic_l4");
  endtask

  task automatic test_back_to_back;
    fetch(0, 32'h60, 1'b1, "b2b_first");
    fetch(0, 32'h64, 1'b0, "b2b_second");
    fetch(2, 32'h6C, 1'b1, "b2b_l3_first");
    fetch(2, 32'h70, 1'b0, "b2b_l3_second");
  endtask

  task automatic test_abort;
    bit seen;
    rd[3] = 1'b1; addr[3] = 32'h6C;
    tick; tick;
    rd[3] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (resp[3]) seen = 1'b1;
    end
    n_chk++;
    if (seen || dout[3] !== last_in[3])
      $display("FAIL abort: resp_seen=%b in=%h expected 0/%h", seen, dout[3], last_in[3]);
    else n_pass++;
    fetch(3, 32'h68, 1'b0, "after_abort");
  endtask

  task automatic test_reset_mid;
    bit seen;
    rd[2] = 1'b1; addr[2] = 32'h74;
    tick; tick;
    rst = 1'b1;
    #1;
    n_chk++;
    if (resp[2] !== 1'b0 || dout[2] !== NOP_INSTR)
      $display("FAIL rst_mid_wait: resp=%b in=%h expected 0/%h", resp[2], dout[2], NOP_INSTR);
    else n_pass++;
    rd[2] = 1'b0;
    tick;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (resp[2]) seen = 1'b1;
    end
    n_chk++;
    if (seen || dout[2] !== NOP_INSTR)
      $display("FAIL rst_no_resp: resp_seen=%b in=%h expected 0/%h", seen, dout[2], NOP_INSTR);
    else n_pass++;
    for (int l = 0; l < 4; l++) last_in[l] = NOP_INSTR;
    fetch(2, 32'h74, 1'b0, "after_rst_wait");
    // reset while the response pulse is up
    rd[1] = 1'b1; addr[1] = 32'h78;
    tick; tick;
    rst = 1'b1;
    #1;
    n_chk++;
    if (resp[1] !== 1'b0 || dout[1] !== NOP_INSTR)
      $display("FAIL rst_mid_resp: resp=%b in=%h expected 0/%h", resp[1], dout[1], NOP_INSTR);
    else n_pass++;
    rd[1] = 1'b0;
    tick;
    rst = 1'b0;
    tick;
    for (int l = 0; l < 4; l++) last_in[l] = NOP_INSTR;
    fetch(1, 32'h78, 1'b0, "after_rst_resp");
  endtask

  task automatic test_fault;
    fetch(1, 32'h62, 1'b0, "misaligned");
    fetch(3, BASE + 32'(4 * DEPTH), 1'b0, "past_end");
    fetch(0, 32'h5C, 1'b0, "below_base");
    fetch(2, LAST, 1'b0, "last_word");
  endtask

  task automatic test_rbw;
    logic [31:0] oldw, nw;
    oldw = mdl[m_idx(32'h60)];
    nw = $urandom;
    rd[1] = 1'b1; addr[1] = 32'h60;
    tick;
    pwe = 1'b1; paddr = 32'h60; pdata = nw;
    tick;
    pwe = 1'b0;
    n_chk++;
    if (resp[1] !== 1'b1 || dout[1] !== oldw)
      $display("FAIL rbw_old: resp=%b in=%h expected 1/%h", resp[1], dout[1], oldw);
    else n_pass++;
    mdl[m_idx(32'h60)] = nw;
    last_in[1] = oldw;
    last_resp[1] = cyc;
    rd[1] = 1'b0;
    tick;
    fetch(1, 32'h60, 1'b0, "rbw_new");
  endtask

  task automatic test_random;
    int ln, prev_ln;
    bit hold, prev_hold;
    logic [31:0] a;
    prev_hold = 1'b0;
    prev_ln = 0;
    for (int i = 0; i < 40; i++) begin
      ln = prev_hold ? prev_ln : int'($urandom_range(0, 3));
      if (!prev_hold && $urandom_range(0, 2) == 0) prog($urandom_range(0, 32'h7FF), $urandom);
      if ($urandom_range(0, 3) != 0) a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
      else a = $urandom_range(0, 32'h7FF);
      hold = (i < 39) && ($urandom_range(0, 1) == 1);
      fetch(ln, a, hold, "random");
      prev_hold = hold;
      prev_ln = ln;
    end
  endtask

  initial begin
    for (int l = 0; l < 4; l++) begin
      addr[l] = '0;
      last_in[l] = NOP_INSTR;
      last_resp[l] = -100;
    end
    test_reset;
    test_preload;
    test_basic;
    test_back_to_back;
    test_abort;
    test_reset_mid;
    test_fault;
    test_rbw;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
